control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the single-bus datapath's control strobes, replacing bench-driven sequencing.
//  Runs fetch (T0-T2), then an opcode-specific execute sequence (T3-T7), and loops back to T0.
//  Supports ld, ldi, st, add, sub, and, or, addi, nop and halt. Inserts memory wait states from mem_ready.
//  Sits beside the datapath: takes the IR contents back and emits every select/enable plus the ALU op.
// PARAMETERS
//  MAX_WAIT  15  wait cycles allowed in one memory state before mem_err; max 255
//  OP_ADD    4'b0010 / OP_SUB 4'b0011 / OP_AND 4'b0000 / OP_OR 4'b0001  ALU op encodings
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high
//  ir         in   32  IR register output; opcode ir[31:27]
//  mem_ready  in   1   memory completes the read/write this cycle
//  stop       in   1   request halt at the next instruction boundary
//  pc_out, z_low_out, mdr_out, r_out, ba_out, c_out  out 1  bus drivers (at most one high per cycle)
//  mar_in, pc_in, ir_in, y_in, z_in, mdr_in, r_in    out 1  register load enables
//  gra, grb, grc    out 1  register-field selects
//  inc_pc, read, write  out 1  PC-increment mode; memory strobes
//  alu_op     out  4   ALU function
//  run        out  1   high while sequencing; low in RST and HALT
//  mem_err    out  1   sticky; set when a wait exceeds MAX_WAIT
// BEHAVIOUR
//  - Reset (async): state=RST, wait_cnt=0, mem_err=0; every output 0, alu_op=0.
//  - One state per clock. Outputs decode combinationally from the registered state and ir.
//  - RST -> T0 on the first clock after reset is released.
//  - Fetch:
//    T0: pc_out mar_in inc_pc z_in alu_op=ADD
//    T1: z_low_out pc_in read mdr_in; hold in T1 while !mem_ready
//    T2: mdr_out ir_in
//  - Opcode is taken from ir starting in T3.
//  - ld 00000:
//    T3 grb ba_out y_in | T4 c_out z_in ADD | T5 z_low_out mar_in
//    T6 read mdr_in (wait on mem_ready) | T7 mdr_out gra r_in
//  - ldi 00001: T3/T4 as ld | T5 z_low_out gra r_in.
//  - st 00010: T3-T5 as ld | T6 gra r_out mdr_in | T7 write (wait on mem_ready).
//  - add/sub/and/or 00011/00100/00101/00110:
//    T3 grb r_out y_in | T4 grc r_out z_in alu_op=op | T5 z_low_out gra r_in
//  - addi 01100: T3 grb r_out y_in | T4 c_out z_in ADD | T5 z_low_out gra r_in.
//  - nop 11010 or any undefined opcode: T3 with no strobes.
//  - halt 11011: T3 -> HALT.
//  - After an instruction's last state: next is HALT if stop=1, else T0.
//  - HALT exits only by reset.
//  - Wait states: wait_cnt increments each stalled cycle and clears on leaving the state.
//    When wait_cnt reaches MAX_WAIT with mem_ready still 0: mem_err=1, next state HALT.
//  - mem_ready high in a non-memory state is ignored.
//  - During a wait the state's strobes stay asserted. pc_in repeats the same Z value, which is harmless.
//  - Reset mid-instruction aborts immediately; no strobe glitches after reset asserts.
// TESTING
//  1 Reset 3 cycles, mem_ready=1, ir=32'h00800055 (ld R1,0x55(R0))
//    -> RST,T0..T7,T0; strobes exactly as listed; 8 clocks per ld.
//  2 add (ir=32'h18918000), mem_ready=1
//    -> T4 shows grc=1 r_out=1 z_in=1 alu_op=4'b0010; back at T0 after T5.
//  3 st, mem_ready low for 3 cycles in T7
//    -> write held 4 cycles; then T0; mem_err=0.
//  4 mem_ready held low in T1 with MAX_WAIT=15
//    -> mem_err=1 and run=0 on cycle 16; stays HALT.
//  5 halt opcode 5'b11011, then stop=1 on a separate ld
//    -> HALT after T3 / after T7; run=0; reset returns to RST.
//  6 reset asserted during T6 of ld -> all outputs 0 the same cycle; clean refetch from T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch in T0-T2, opcode-specific execute in T3-T7.
// Memory states stall on mem_ready; an over-long stall latches mem_err and parks the sequencer in HALT.
module control_sequencer #(
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [3:0]  OP_ADD   = 4'b0010,
    parameter logic [3:0]  OP_SUB   = 4'b0011,
    parameter logic [3:0]  OP_AND   = 4'b0000,
    parameter logic [3:0]  OP_OR    = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        pc_out,
    output logic        z_low_out,
    output logic        mdr_out,
    output logic        r_out,
    output logic        ba_out,
    output logic        c_out,
    output logic        mar_in,
    output logic        pc_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        mdr_in,
    output logic        r_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        inc_pc,
    output logic        read,
    output logic        write,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        mem_err
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [4:0]         opc;
    logic               is_ldst_c;
    logic               is_rr_c;
    logic               is_addi_c;
    logic               mem_state_c;
    logic               stall_c;
    logic               timeout_c;
    logic [3:0]         alu_sel_c;
    logic               unused_ir_bits;

    assign opc            = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];
    assign is_ldst_c      = opc inside {OPC_LD, OPC_LDI, OPC_ST};
    assign is_rr_c        = opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR};
    assign is_addi_c      = (opc == OPC_ADDI);

    // States that wait on the memory handshake
    assign mem_state_c = (state == S_T1) ||
                         (state == S_T6 && opc == OPC_LD) ||
                         (state == S_T7 && opc == OPC_ST);
    assign stall_c     = mem_state_c && !mem_ready;
    assign timeout_c   = stall_c && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        case (opc)
            OPC_SUB: alu_sel_c = OP_SUB;
            OPC_AND: alu_sel_c = OP_AND;
            OPC_OR:  alu_sel_c = OP_OR;
            default: alu_sel_c = OP_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RST;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (stall_c && !timeout_c) ? wait_cnt + WAIT_W'(1) : '0;
            if (timeout_c) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next state; a stall overrides the nominal successor
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (opc == OPC_HALT)                  state_nxt = S_HALT;
                else if (is_ldst_c || is_rr_c || is_addi_c) state_nxt = S_T4;
                else                                  state_nxt = stop ? S_HALT : S_T0;
            end
            S_T4:   state_nxt = S_T5;
            S_T5: begin
                if (opc == OPC_LD || opc == OPC_ST)   state_nxt = S_T6;
                else                                  state_nxt = stop ? S_HALT : S_T0;
            end
            S_T6:   state_nxt = S_T7;
            S_T7:   state_nxt = stop ? S_HALT : S_T0;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
        if (stall_c) begin
            state_nxt = timeout_c ? S_HALT : state;
        end
    end

    // Strobe decode from the registered state and the IR opcode
    always_comb begin
        pc_out = 1'b0; z_low_out = 1'b0; mdr_out = 1'b0; r_out = 1'b0;
        ba_out = 1'b0; c_out = 1'b0; mar_in = 1'b0; pc_in = 1'b0;
        ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; mdr_in = 1'b0; r_in = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; inc_pc = 1'b0;
        read = 1'b0; write = 1'b0; alu_op = 4'b0000;
        run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = OP_ADD;
            end
            S_T1: begin
                z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                if (is_ldst_c) begin
                    grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                end else if (is_rr_c || is_addi_c) begin
                    grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                end
            end
            S_T4: begin
                if (is_rr_c) begin
                    grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_sel_c;
                end else if (is_ldst_c || is_addi_c) begin
                    c_out = 1'b1; z_in = 1'b1; alu_op = OP_ADD;
                end
            end
            S_T5: begin
                if (opc == OPC_LD || opc == OPC_ST) begin
                    z_low_out = 1'b1; mar_in = 1'b1;
                end else if (opc == OPC_LDI || is_rr_c || is_addi_c) begin
                    z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end
            end
            S_T6: begin
                if (opc == OPC_LD) begin
                    read = 1'b1; mdr_in = 1'b1;
                end else if (opc == OPC_ST) begin
                    gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
                end
            end
            S_T7: begin
                if (opc == OPC_LD) begin
                    mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if (opc == OPC_ST) begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
